mac_burst_arbiter: RTL

- Shares one external WIDTH x WIDTH multiplier (the MULT/FMA datapath under exploration) between NREQ requesters.
- Each requester submits a dot-product burst as a stream of (a, b) pairs, with a last flag on the final pair.
- The block grants bursts round-robin and issues each pair to the multiplier.
- It tracks the multiplier's fixed pipeline latency, accumulates the products, and returns one result per burst tagged with the requester id.

---
 rtl/mac_burst_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mac_burst_arbiter.sv
// Round-robin arbiter that shares one external pipelined multiplier among NREQ
// requesters, accumulating each granted dot-product burst into one tagged result.
module mac_burst_arbiter #(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 4,
    parameter  int LAT   = 2,
    parameter  int GUARD = 4,
    localparam int ACC_W = 2*WIDTH + GUARD,
    localparam int ID_W  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_last,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    output logic                  mul_valid,
    input  logic [2*WIDTH-1:0]    mul_p,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_W-1:0]      res_data,
    output logic [ID_W-1:0]       res_id,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN, RESULT} state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] res_data_q, res_data_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;
    logic [LAT-1:0]   vld_p_q, vld_p_d;
    logic [LAT-1:0]   lst_p_q, lst_p_d;

    logic             hs, hs_last, tap, tap_last;
    logic             found;
    logic [ID_W-1:0]  gsel, idx;

    // Unsigned accumulate; carries beyond ACC_W are intentionally dropped.
    function automatic logic [ACC_W-1:0] acc_wrap_add(input logic [ACC_W-1:0] acc,
                                                      input logic [2*WIDTH-1:0] p);
        return acc + ACC_W'(p);
    endfunction

    always_comb begin
        mul_a     = '0;
        mul_b     = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                mul_a = req_a[i*WIDTH +: WIDTH];
                mul_b = req_b[i*WIDTH +: WIDTH];
                req_ready[i] = (state_q == BURST);
            end
        end
    end

    assign hs        = (state_q == BURST) && req_valid[grant_q];
    assign hs_last   = hs && req_last[grant_q];
    assign mul_valid = hs;
    assign tap       = vld_p_q[LAT-1];
    assign tap_last  = lst_p_q[LAT-1];

    // Round-robin search starting just above the previous winner.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = ID_W'((int'(last_grant_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gsel  = idx;
            end
        end
    end

    always_comb begin
        vld_p_d[0] = hs;
        lst_p_d[0] = hs_last;
        for (int i = 1; i < LAT; i++) begin
            vld_p_d[i] = vld_p_q[i-1];
            lst_p_d[i] = lst_p_q[i-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        acc_d        = tap ? acc_wrap_add(acc_q, mul_p) : acc_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        res_valid_d  = res_valid_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d      = gsel;
                    last_grant_d = gsel;
                    acc_d        = '0;
                    state_d      = BURST;
                end
            end
            BURST: begin
                if (hs_last) state_d = DRAIN;
            end
            DRAIN: begin
                // The final product lands this cycle; publish the updated sum.
                if (tap && tap_last) begin
                    state_d     = RESULT;
                    res_valid_d = 1'b1;
                    res_data_d  = acc_d;
                    res_id_d    = grant_q;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NREQ-1);
            acc_q        <= '0;
            res_data_q   <= '0;
            res_id_q     <= '0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            vld_p_q      <= '0;
            lst_p_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            acc_q        <= acc_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
            vld_p_q      <= vld_p_d;
            lst_p_q      <= lst_p_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;

endmodule
